fifo_rd_pack: RTL and testbench

Read-side drain and width packer that sits directly downstream of the async FIFO, in the `rclk` domain. It pops `D_SIZE`-bit words through the FIFO's `ren`/`empty`/`rdata` interface and assembles `RATIO` consecutive words into one wide beat. Each beat is presented on a valid/ready output interface. A flush request emits a partial beat, so trailing words are never stranded.

---
 rtl/fifo_rd_pack.sv | 105 ++++++++++
 tb/tb_fifo_rd_pack.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_pack.sv
// Read-side drain and width packer: pops D_SIZE-bit words from the async FIFO and packs RATIO of them per beat.
// Optional beat statistics counter on stat_beats is built only when FIFO_RD_PACK_STAT_EN is defined.
module fifo_rd_pack #(
  parameter int D_SIZE = 8,
  parameter int RATIO  = 4,
  localparam int CW    = $clog2(RATIO + 1)
) (
  input  logic                     rclk,
  input  logic                     rrst,
  input  logic                     empty,
  input  logic [D_SIZE-1:0]        rdata,
  output logic                     ren,
  input  logic                     flush,
  output logic [RATIO*D_SIZE-1:0]  out_data,
  output logic [CW-1:0]            out_cnt,
  output logic                     out_valid,
  input  logic                     out_ready
`ifdef FIFO_RD_PACK_STAT_EN
  ,
  output logic [15:0]              stat_beats
`endif
);

  localparam int AW = $clog2(RATIO);
  localparam logic [AW-1:0] LAST = AW'(RATIO - 1);

  logic [RATIO*D_SIZE-1:0] acc_q, acc_d, acc_wr;
  logic [AW-1:0]           acc_cnt_q, acc_cnt_d;
  logic                    flush_pend_q, flush_pend_d;
  logic [RATIO*D_SIZE-1:0] out_data_q, out_data_d;
  logic [CW-1:0]           out_cnt_q, out_cnt_d;
  logic                    out_valid_q, out_valid_d;
  logic                    out_free, pop, full, flush_req, serve;
  logic [CW-1:0]           part_cnt;

  always_comb begin
    out_free  = !out_valid_q || out_ready;
    pop       = !empty && ((acc_cnt_q != LAST) || out_free);
    full      = pop && (acc_cnt_q == LAST);
    part_cnt  = CW'(acc_cnt_q) + CW'(pop);
    flush_req = flush_pend_q || flush;
    // A full beat wins over a flush; the accumulator is empty afterwards anyway.
    serve     = flush_req && (part_cnt != '0) && out_free && !full;

    acc_wr = acc_q;
    for (int i = 0; i < RATIO; i++) begin
      if (pop && (acc_cnt_q == AW'(i))) acc_wr[i*D_SIZE +: D_SIZE] = rdata;
    end

    acc_d        = acc_wr;
    acc_cnt_d    = pop ? acc_cnt_q + AW'(1) : acc_cnt_q;
    out_data_d   = out_data_q;
    out_cnt_d    = out_cnt_q;
    out_valid_d  = out_ready ? 1'b0 : out_valid_q;
    flush_pend_d = flush_req && !full && !serve && (part_cnt != '0);

    // Lanes above the fill count are already zero, so a partial beat needs no masking.
    if (full || serve) begin
      out_data_d  = acc_wr;
      out_cnt_d   = part_cnt;
      out_valid_d = 1'b1;
      acc_d       = '0;
      acc_cnt_d   = '0;
    end
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      acc_q        <= '0;
      acc_cnt_q    <= '0;
      flush_pend_q <= 1'b0;
      out_data_q   <= '0;
      out_cnt_q    <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      acc_cnt_q    <= acc_cnt_d;
      flush_pend_q <= flush_pend_d;
      out_data_q   <= out_data_d;
      out_cnt_q    <= out_cnt_d;
      out_valid_q  <= out_valid_d;
    end
  end

`ifdef FIFO_RD_PACK_STAT_EN
  logic [15:0] stat_q, stat_d;

  always_comb begin
    stat_d = stat_q + 16'(out_valid_q && out_ready);
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) stat_q <= '0;
    else      stat_q <= stat_d;
  end

  assign stat_beats = stat_q;
`endif

  assign ren       = pop && !rrst;
  assign out_data  = out_data_q;
  assign out_cnt   = out_cnt_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_fifo_rd_pack.sv
// Directed bench for fifo_rd_pack with a behavioural FIFO model feeding empty/rdata.
module tb_fifo_rd_pack;

  logic        rclk = 1'b0;
  logic        rrst = 1'b1;
  logic        empty;
  logic [7:0]  rdata;
  logic        ren;
  logic        flush = 1'b0;
  logic [31:0] out_data;
  logic [2:0]  out_cnt;
  logic        out_valid;
  logic        out_ready = 1'b1;
`ifdef FIFO_RD_PACK_STAT_EN
  logic [15:0] stat_beats;
`endif

  logic [7:0] fq[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         npops = 0;

  fifo_rd_pack #(.D_SIZE(8), .RATIO(4)) dut (
    .rclk      (rclk),
    .rrst      (rrst),
    .empty     (empty),
    .rdata     (rdata),
    .ren       (ren),
    .flush     (flush),
    .out_data  (out_data),
    .out_cnt   (out_cnt),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef FIFO_RD_PACK_STAT_EN
    ,
    .stat_beats(stat_beats)
`endif
  );

  always #5 rclk = ~rclk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic fifo_upd();
    empty = (fq.size() == 0);
    rdata = empty ? 8'h00 : fq[0];
  endtask

  task automatic push(input logic [7:0] w);
    fq.push_back(w);
    fifo_upd();
  endtask

  // One clock: sample ren mid-cycle, let the edge happen, then retire the popped word.
  task automatic tick();
    logic p;
    @(negedge rclk);
    p = ren;
    @(posedge rclk);
    #1;
    if (p) begin
      void'(fq.pop_front());
      npops++;
    end
    fifo_upd();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  initial begin
    fifo_upd();
    push(8'h99);
    ticks(2);
    chk("rst_ren_gated", 64'(ren), 64'h0);
    chk("rst_valid", 64'(out_valid), 64'h0);
    chk("rst_data", 64'(out_data), 64'h0);
    chk("rst_cnt", 64'(out_cnt), 64'h0);
    fq.delete();
    fifo_upd();
    rrst = 1'b0;
    ticks(1);

    // Full beat with downstream ready
    npops = 0;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    ticks(4);
    chk("full_pops", 64'(npops), 64'd4);
    chk("full_valid", 64'(out_valid), 64'h1);
    chk("full_data", 64'(out_data), 64'h44332211);
    chk("full_cnt", 64'(out_cnt), 64'd4);
    tick();
    chk("full_drop", 64'(out_valid), 64'h0);

    // Back-pressure: 8 words, stalled output
    npops = 0;
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push(8'(i));
    ticks(10);
    chk("bp_pops", 64'(npops), 64'd7);
    chk("bp_ren_low", 64'(ren), 64'h0);
    chk("bp_hold_data", 64'(out_data), 64'h04030201);
    chk("bp_hold_valid", 64'(out_valid), 64'h1);
    out_ready = 1'b1;
    tick();
    chk("bp_b2_valid", 64'(out_valid), 64'h1);
    chk("bp_b2_data", 64'(out_data), 64'h08070605);
    chk("bp_b2_cnt", 64'(out_cnt), 64'd4);
    tick();
    chk("bp_drop", 64'(out_valid), 64'h0);
    chk("bp_pops_all", 64'(npops), 64'd8);

    // Flush of a partial beat, then a flush with nothing accumulated
    push(8'hA1); push(8'hA2);
    ticks(3);
    chk("fl_no_beat_yet", 64'(out_valid), 64'h0);
    pulse_flush();
    chk("fl_valid", 64'(out_valid), 64'h1);
    chk("fl_data", 64'(out_data), 64'h0000A2A1);
    chk("fl_cnt", 64'(out_cnt), 64'd2);
    tick();
    chk("fl_drop", 64'(out_valid), 64'h0);
    pulse_flush();
    chk("fl_empty_none", 64'(out_valid), 64'h0);
    tick();
    chk("fl_empty_none2", 64'(out_valid), 64'h0);

    // Flush in the same cycle as a pop
    push(8'h4B);
    ticks(2);
    push(8'h5C);
    pulse_flush();
    chk("flp_valid", 64'(out_valid), 64'h1);
    chk("flp_cnt", 64'(out_cnt), 64'd2);
    chk("flp_data", 64'(out_data), 64'h00005C4B);
    tick();
    chk("flp_drop", 64'(out_valid), 64'h0);

    // Flush held pending behind a stalled beat
    out_ready = 1'b0;
    push(8'hB1); push(8'hB2); push(8'hB3); push(8'hB4); push(8'hC1);
    ticks(6);
    pulse_flush();
    ticks(2);
    chk("pend_hold_data", 64'(out_data), 64'hB4B3B2B1);
    chk("pend_hold_cnt", 64'(out_cnt), 64'd4);
    out_ready = 1'b1;
    tick();
    chk("pend_valid", 64'(out_valid), 64'h1);
    chk("pend_data", 64'(out_data), 64'h000000C1);
    chk("pend_cnt", 64'(out_cnt), 64'd1);
    tick();
    chk("pend_drop", 64'(out_valid), 64'h0);
`ifdef FIFO_RD_PACK_STAT_EN
    chk("stat_count", 64'(stat_beats), 64'd7);
`endif

    // Asynchronous reset with a held beat and a partial accumulator
    out_ready = 1'b0;
    push(8'hD1); push(8'hD2); push(8'hD3); push(8'hD4); push(8'hE1); push(8'hE2);
    ticks(6);
    chk("mid_valid_pre", 64'(out_valid), 64'h1);
    #2;
    rrst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'h0);
    chk("mid_rst_data", 64'(out_data), 64'h0);
    chk("mid_rst_cnt", 64'(out_cnt), 64'h0);
    chk("mid_rst_ren", 64'(ren), 64'h0);
`ifdef FIFO_RD_PACK_STAT_EN
    chk("mid_rst_stat", 64'(stat_beats), 64'h0);
`endif
    fq.delete();
    fifo_upd();
    tick();
    #2;
    rrst = 1'b0;
    out_ready = 1'b1;
    push(8'hF1); push(8'hF2); push(8'hF3); push(8'hF4);
    ticks(4);
    chk("post_rst_valid", 64'(out_valid), 64'h1);
    chk("post_rst_data", 64'(out_data), 64'hF4F3F2F1);
    tick();
    chk("post_rst_drop", 64'(out_valid), 64'h0);
`ifdef FIFO_RD_PACK_STAT_EN
    chk("post_rst_stat", 64'(stat_beats), 64'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
